// File: rtl/regbank_wr_demux_pkg.sv
// Shared definitions for the register-bank write demux and its load buffer.
// Holds the bank geometry, the buffer depth and the buffered write-back entry
// type. It also provides an address-to-one-hot helper used for bank write
// enables and the pending-register mask.
package regbank_wr_demux_pkg;

  localparam int NUM_REGS   = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [NUM_REGS-1:0] onehot_t;

  // One buffered load write-back. live drops when a younger ALU write to the
  // same register makes this entry stale; the slot is still kept and popped.
  typedef struct packed {
    logic  live;
    addr_t addr;
    data_t data;
  } wb_entry_t;

  function automatic onehot_t addr_to_onehot(input addr_t a);
    onehot_t oh;
    oh    = '0;
    oh[a] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regbank_wr_demux_wb_fifo2.sv
// wb_fifo2: two-entry in-order load write-back buffer with per-entry kill.
// Ports:
//   clk, reset_n          clock, async active-low reset (empties the buffer)
//   i_push, i_push_addr/data  enqueue one entry (caller has already handshaken)
//   i_pop_allow           head may leave this cycle (bank write port is free)
//   i_kill_valid/addr     younger ALU write; live entries with this addr die
//   o_push_ready          space available, counting a pop in this same cycle
//   o_pop                 head leaves at the coming edge
//   o_head_live/addr/data head entry contents
//   o_pend_mask           OR of one-hot(addr) over occupied live entries
//   o_count               occupied entries, 0..2
module wb_fifo2
  import regbank_wr_demux_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  addr_t            i_push_addr,
  input  data_t            i_push_data,
  input  logic             i_pop_allow,
  input  logic             i_kill_valid,
  input  addr_t            i_kill_addr,
  output logic             o_push_ready,
  output logic             o_pop,
  output logic             o_head_live,
  output addr_t            o_head_addr,
  output data_t            o_head_data,
  output onehot_t          o_pend_mask,
  output logic [CNT_W-1:0] o_count
);

  wb_entry_t        r_entry [FIFO_DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic [FIFO_DEPTH-1:0] w_occ;
  onehot_t          w_pend;

  assign w_pop        = (r_count != '0) && i_pop_allow;
  assign o_pop        = w_pop;
  assign o_push_ready = (r_count < CNT_W'(FIFO_DEPTH)) || w_pop;
  assign o_head_live  = r_entry[r_rd_ptr].live;
  assign o_head_addr  = r_entry[r_rd_ptr].addr;
  assign o_head_data  = r_entry[r_rd_ptr].data;
  assign o_count      = r_count;
  assign o_pend_mask  = w_pend;

  // Slot occupancy derived from count and read pointer.
  always_comb begin
    w_occ = '0;
    if (r_count == CNT_W'(2)) begin
      w_occ = '1;
    end else if (r_count == CNT_W'(1)) begin
      w_occ[r_rd_ptr] = 1'b1;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_occ[i] && r_entry[i].live) begin
        w_pend = w_pend | addr_to_onehot(r_entry[i].addr);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      // Kill first; a push into a slot in the same cycle is written after and
      // wins, so an entry arriving alongside the ALU write stays live.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (i_kill_valid && r_entry[i].live && (r_entry[i].addr == i_kill_addr)) begin
          r_entry[i].live <= 1'b0;
        end
      end
      if (i_push) begin
        r_entry[r_wr_ptr] <= '{live: 1'b1, addr: i_push_addr, data: i_push_data};
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regbank_wr_demux.sv
// regbank_wr_demux: 16 x 32 register bank with two write-back ports.
// Port A (ALU) writes the bank directly and always wins the write port.
// Port B (load) is valid/ready and always goes through a 2-entry buffer.
// That buffer drains only in cycles when port A is idle. An ALU write kills
// any buffered load to the same register, because the ALU result is younger.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   wr_valid_a/addr_a/data_a     ALU write-back, always accepted
//   wr_valid_b/ready_b/addr_b/data_b  load write-back handshake
//   regs_flat                    register i on bits [32i+31:32i]
//   commit_onehot                bank write enable this cycle (one-hot or 0)
//   pend_mask                    registers with a live buffered load
//   fifo_count                   occupied buffer entries
// HARD_ZERO=1 makes register 0 a constant zero; writes to it are dropped.
module regbank_wr_demux
  import regbank_wr_demux_pkg::*;
#(
  parameter int HARD_ZERO = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_valid_a,
  input  logic [ADDR_W-1:0]          wr_addr_a,
  input  logic [DATA_W-1:0]          wr_data_a,
  input  logic                       wr_valid_b,
  output logic                       wr_ready_b,
  input  logic [ADDR_W-1:0]          wr_addr_b,
  input  logic [DATA_W-1:0]          wr_data_b,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        commit_onehot,
  output logic [NUM_REGS-1:0]        pend_mask,
  output logic [1:0]                 fifo_count
);

  data_t   r_regs [NUM_REGS];

  logic    w_a_drop;
  logic    w_a_commit;
  logic    w_ready_b;
  logic    w_b_drop;
  logic    w_push;
  logic    w_pop;
  logic    w_head_live;
  addr_t   w_head_addr;
  data_t   w_head_data;
  logic    w_b_commit;
  onehot_t w_commit;
  data_t   w_wdata;
  onehot_t w_pend;
  logic [CNT_W-1:0] w_count;

  assign w_a_drop   = (HARD_ZERO != 0) && (wr_addr_a == '0);
  assign w_b_drop   = (HARD_ZERO != 0) && (wr_addr_b == '0);
  assign w_a_commit = reset_n && wr_valid_a && !w_a_drop;

  // A dropped x0 load still completes its handshake; it just never enqueues.
  assign w_push     = wr_valid_b && w_ready_b && !w_b_drop;

  wb_fifo2 u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_push_addr  (wr_addr_b),
    .i_push_data  (wr_data_b),
    .i_pop_allow  (!wr_valid_a),
    .i_kill_valid (wr_valid_a && !w_a_drop),
    .i_kill_addr  (wr_addr_a),
    .o_push_ready (w_ready_b),
    .o_pop        (w_pop),
    .o_head_live  (w_head_live),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_pend_mask  (w_pend),
    .o_count      (w_count)
  );

  // Pops happen only with port A idle, so the two commit sources never collide.
  assign w_b_commit = reset_n && w_pop && w_head_live;

  always_comb begin
    w_commit = '0;
    w_wdata  = wr_data_a;
    if (w_a_commit) begin
      w_commit = addr_to_onehot(wr_addr_a);
      w_wdata  = wr_data_a;
    end else if (w_b_commit) begin
      w_commit = addr_to_onehot(w_head_addr);
      w_wdata  = w_head_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit[i]) begin
          r_regs[i] <= w_wdata;
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
    end
    if (HARD_ZERO != 0) begin
      regs_flat[DATA_W-1:0] = '0;
    end
  end

  // Buffer count is already 0 in reset; the OR keeps ready high regardless.
  assign wr_ready_b    = w_ready_b || !reset_n;
  assign commit_onehot = w_commit;
  assign pend_mask     = w_pend;
  assign fifo_count    = w_count;

endmodule

// File: tb/tb_regbank_wr_demux.sv
module tb_regbank_wr_demux;

  typedef struct packed {
    logic [15:0] oh;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance 0: HARD_ZERO = 0
  logic         a_v = 0, b_v = 0, b_rdy;
  logic [3:0]   a_addr = 0, b_addr = 0;
  logic [31:0]  a_data = 0, b_data = 0;
  logic [511:0] flat0;
  logic [15:0]  commit0, pend0;
  logic [1:0]   cnt0;

  // Instance 1: HARD_ZERO = 1
  logic         h_a_v = 0, h_b_v = 0, h_b_rdy;
  logic [3:0]   h_a_addr = 0, h_b_addr = 0;
  logic [31:0]  h_a_data = 0, h_b_data = 0;
  logic [511:0] flat1;
  logic [15:0]  commit1, pend1;
  logic [1:0]   cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  regbank_wr_demux #(.HARD_ZERO(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n),
    .wr_valid_a(a_v), .wr_addr_a(a_addr), .wr_data_a(a_data),
    .wr_valid_b(b_v), .wr_ready_b(b_rdy), .wr_addr_b(b_addr), .wr_data_b(b_data),
    .regs_flat(flat0), .commit_onehot(commit0), .pend_mask(pend0), .fifo_count(cnt0)
  );

  regbank_wr_demux #(.HARD_ZERO(1)) u_dut1 (
    .clk(clk), .reset_n(rst_n),
    .wr_valid_a(h_a_v), .wr_addr_a(h_a_addr), .wr_data_a(h_a_data),
    .wr_valid_b(h_b_v), .wr_ready_b(h_b_rdy), .wr_addr_b(h_b_addr), .wr_data_b(h_b_data),
    .regs_flat(flat1), .commit_onehot(commit1), .pend_mask(pend1), .fifo_count(cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) if (oh[i]) idx = i;
    return idx;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every nonzero commit pops the next expected write;
  // the written value is checked on the register one cycle later.
  logic        m0_pend = 0;
  int          m0_idx  = 0;
  logic [31:0] m0_data = 0;
  always @(negedge clk) begin
    exp_t e;
    if (m0_pend && rst_n) check("m0_regval", flat0[32*m0_idx +: 32], m0_data);
    m0_pend = 1'b0;
    if (rst_n && commit0 != 16'h0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL m0_unexpected: got commit %h expected none", commit0);
      end else begin
        e = q0.pop_front();
        check("m0_commit", 32'(commit0), 32'(e.oh));
        m0_idx  = oh_idx(e.oh);
        m0_data = e.data;
        m0_pend = 1'b1;
      end
    end
  end

  logic        m1_pend = 0;
  int          m1_idx  = 0;
  logic [31:0] m1_data = 0;
  always @(negedge clk) begin
    exp_t e;
    if (m1_pend && rst_n) check("m1_regval", flat1[32*m1_idx +: 32], m1_data);
    m1_pend = 1'b0;
    if (rst_n && commit1 != 16'h0) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL m1_unexpected: got commit %h expected none", commit1);
      end else begin
        e = q1.pop_front();
        check("m1_commit", 32'(commit1), 32'(e.oh));
        m1_idx  = oh_idx(e.oh);
        m1_data = e.data;
        m1_pend = 1'b1;
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_cnt", 32'(cnt0), 0);
    check("rst_pend", 32'(pend0), 0);
    check("rst_rdy", 32'(b_rdy), 1);
    check("rst_commit", 32'(commit0), 0);
    for (int i = 0; i < 16; i++) check("rst_reg", flat0[32*i +: 32], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();

    // Port A r5 = DEADBEEF
    a_v = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    q0.push_back('{oh: 16'h0020, data: 32'hDEADBEEF});
    #1 check("a_commit_r5", 32'(commit0), 32'h0020);
    cyc();
    a_v = 0;
    #1 check("a_r5", flat0[32*5 +: 32], 32'hDEADBEEF);

    // Port B r3 = 0x11, A idle
    b_v = 1; b_addr = 3; b_data = 32'h11;
    q0.push_back('{oh: 16'h0008, data: 32'h11});
    #1 check("b_rdy_empty", 32'(b_rdy), 1);
    check("b_no_direct", 32'(commit0), 0);
    cyc();
    b_v = 0;
    #1 check("b_cnt1", 32'(cnt0), 1);
    check("b_pend_r3", 32'(pend0), 32'h0008);
    check("b_commit_r3", 32'(commit0), 32'h0008);
    cyc();
    check("b_r3", flat0[32*3 +: 32], 32'h11);
    check("b_cnt0", 32'(cnt0), 0);

    // Two B pushes while A busy for 3 cycles
    q0.push_back('{oh: 16'h0100, data: 32'h80});
    q0.push_back('{oh: 16'h0200, data: 32'h90});
    q0.push_back('{oh: 16'h0400, data: 32'hA0});
    q0.push_back('{oh: 16'h0002, data: 32'h101});
    q0.push_back('{oh: 16'h0004, data: 32'h202});
    a_v = 1; a_addr = 8; a_data = 32'h80;
    b_v = 1; b_addr = 1; b_data = 32'h101;
    cyc();
    check("st_cnt1", 32'(cnt0), 1);
    check("st_pend1", 32'(pend0), 32'h0002);
    a_addr = 9; a_data = 32'h90;
    b_addr = 2; b_data = 32'h202;
    #1 check("st_rdy_cnt1", 32'(b_rdy), 1);
    cyc();
    check("st_cnt2", 32'(cnt0), 2);
    check("st_pend2", 32'(pend0), 32'h0006);
    a_addr = 10; a_data = 32'hA0;
    b_v = 0;
    #1 check("st_rdy_full", 32'(b_rdy), 0);
    cyc();
    check("st_cnt2_hold", 32'(cnt0), 2);
    a_v = 0;
    #1 check("st_rdy_pop", 32'(b_rdy), 1);
    check("st_commit_r1", 32'(commit0), 32'h0002);
    cyc();
    check("st_cnt_drain", 32'(cnt0), 1);
    #1 check("st_commit_r2", 32'(commit0), 32'h0004);
    cyc();
    check("st_r1", flat0[32*1 +: 32], 32'h101);
    check("st_r2", flat0[32*2 +: 32], 32'h202);

    // Kill: B r7 buffered, then A r7
    a_v = 1; a_addr = 11; a_data = 32'hB11;
    b_v = 1; b_addr = 7; b_data = 32'hAA;
    q0.push_back('{oh: 16'h0800, data: 32'hB11});
    cyc();
    b_v = 0;
    a_addr = 7; a_data = 32'hBB;
    q0.push_back('{oh: 16'h0080, data: 32'hBB});
    #1 check("k_pend_before", 32'(pend0), 32'h0080);
    cyc();
    a_v = 0;
    #1 check("k_cnt", 32'(cnt0), 1);
    check("k_pend_after", 32'(pend0), 0);
    check("k_commit_none", 32'(commit0), 0);
    cyc();
    check("k_cnt0", 32'(cnt0), 0);
    check("k_r7", flat0[32*7 +: 32], 32'hBB);

    // Same-cycle A and B to r12: the B entry stays live
    a_v = 1; a_addr = 12; a_data = 32'hC;
    b_v = 1; b_addr = 12; b_data = 32'hCC;
    q0.push_back('{oh: 16'h1000, data: 32'hC});
    q0.push_back('{oh: 16'h1000, data: 32'hCC});
    cyc();
    a_v = 0; b_v = 0;
    #1 check("sc_pend", 32'(pend0), 32'h1000);
    check("sc_commit", 32'(commit0), 32'h1000);
    cyc();
    check("sc_r12", flat0[32*12 +: 32], 32'hCC);

    // HARD_ZERO=0: r0 is an ordinary register
    a_v = 1; a_addr = 0; a_data = 32'h55;
    q0.push_back('{oh: 16'h0001, data: 32'h55});
    cyc();
    a_v = 0;
    check("r0_normal", flat0[31:0], 32'h55);

    // HARD_ZERO=1: writes to r0 dropped
    h_a_v = 1; h_a_addr = 0; h_a_data = 5;
    h_b_v = 1; h_b_addr = 0; h_b_data = 6;
    #1 check("hz_commit", 32'(commit1), 0);
    check("hz_rdy", 32'(h_b_rdy), 1);
    cyc();
    h_a_v = 0; h_b_v = 0;
    #1 check("hz_cnt", 32'(cnt1), 0);
    check("hz_pend", 32'(pend1), 0);
    check("hz_commit_after", 32'(commit1), 0);
    check("hz_r0", flat1[31:0], 0);
    h_a_v = 1; h_a_addr = 4; h_a_data = 32'h44;
    q1.push_back('{oh: 16'h0010, data: 32'h44});
    cyc();
    h_a_v = 0;
    h_b_v = 1; h_b_addr = 5; h_b_data = 32'h77;
    q1.push_back('{oh: 16'h0020, data: 32'h77});
    cyc();
    h_b_v = 0;
    check("hz_r4", flat1[32*4 +: 32], 32'h44);
    check("hz_cnt_b", 32'(cnt1), 1);
    cyc();
    check("hz_r5", flat1[32*5 +: 32], 32'h77);

    // Full FIFO, then asynchronous reset mid-cycle
    a_v = 1; a_addr = 13; a_data = 32'hD;
    b_v = 1; b_addr = 14; b_data = 32'hE;
    q0.push_back('{oh: 16'h2000, data: 32'hD});
    cyc();
    a_addr = 15; a_data = 32'hF;
    b_addr = 6; b_data = 32'h66;
    q0.push_back('{oh: 16'h8000, data: 32'hF});
    cyc();
    a_addr = 9; a_data = 32'h1;
    b_addr = 1; b_data = 32'h1;
    #1 check("rf_cnt_full", 32'(cnt0), 2);
    check("rf_pend_full", 32'(pend0), 32'h4040);
    rst_n = 1'b0;
    #1 check("rf_cnt", 32'(cnt0), 0);
    check("rf_pend", 32'(pend0), 0);
    check("rf_rdy", 32'(b_rdy), 1);
    check("rf_commit", 32'(commit0), 0);
    for (int i = 0; i < 16; i++) check("rf_reg", flat0[32*i +: 32], 0);
    @(posedge clk); #1;
    a_v = 0; b_v = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("rf_cnt_post", 32'(cnt0), 0);
    check("rf_r14_post", flat0[32*14 +: 32], 0);
    check("rf_r6_post", flat0[32*6 +: 32], 0);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 10; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      cyc();
    end
    cyc();
    check("q0_drain", 32'(q0.size()), 0);
    check("q1_drain", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
